// File: rtl/spmv_pkg.sv
// Shared types and helpers for the CSR spiking SpMV engine.
// State encoding, default geometry and the saturating adder.
package spmv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN
    } state_t;

    localparam int DEF_N_ROWS  = 4;
    localparam int DEF_N_COLS  = 4;
    localparam int DEF_MAX_NNZ = 16;

    localparam int ROW_W = $clog2(DEF_N_ROWS);
    localparam int COL_W = $clog2(DEF_N_COLS);
    localparam int CNT_W = $clog2(DEF_MAX_NNZ + 1);

    // Adds two w-bit unsigned values; clamps or wraps at 2^w-1 (w <= 63).
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          w,
        input bit          sat
    );
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        if (sum > lim) begin
            if (sat) return lim[63:0];
            return sum[63:0] & lim[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/csr_entry_mem.sv
// Register file holding the packed CSR entries (row, col, value).
// One synchronous write port, one combinational read port.
module csr_entry_mem
    import spmv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int RW    = 2,
    parameter int CW    = 2,
    parameter int VW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [RW-1:0] wrow,
    input  logic [CW-1:0] wcol,
    input  logic [VW-1:0] wval,
    input  logic [AW-1:0] raddr,
    output logic [RW-1:0] rrow,
    output logic [CW-1:0] rcol,
    output logic [VW-1:0] rval
);

    localparam int EW = RW + CW + VW;

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= {wrow, wcol, wval};
        end
    end

    assign {rrow, rcol, rval} = mem[raddr];

endmodule

// File: rtl/csr_spmv_engine.sv
// Spiking sparse matrix-vector engine: loads a CSR matrix once,
// then turns each spike vector into N_ROWS streamed row sums.
module csr_spmv_engine
    import spmv_pkg::*;
#(
    parameter int N_ROWS   = DEF_N_ROWS,
    parameter int N_COLS   = DEF_N_COLS,
    parameter int MAX_NNZ  = DEF_MAX_NNZ,
    parameter int VAL_W    = 8,
    parameter int ACC_W    = 8,
    parameter int SATURATE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [$clog2(N_ROWS)-1:0]    load_row,
    input  logic [$clog2(N_COLS)-1:0]    load_col,
    input  logic [VAL_W-1:0]             load_val,
    input  logic                         load_last,
    input  logic                         spike_valid,
    output logic                         spike_ready,
    input  logic [N_COLS-1:0]            spike_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(N_ROWS)-1:0]    out_row,
    output logic [ACC_W-1:0]             out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic [$clog2(MAX_NNZ+1)-1:0] nnz_count,
    output logic                         err_overflow,
    output logic                         err_order
);

    localparam int RW = $clog2(N_ROWS);
    localparam int CW = $clog2(N_COLS);
    localparam int NW = $clog2(MAX_NNZ + 1);
    localparam int PW = $clog2(MAX_NNZ);

    state_t             state;
    logic               matrix_valid;
    logic [RW-1:0]      prev_row;
    logic [N_COLS-1:0]  spike_q;
    logic [NW-1:0]      ptr;
    logic [RW-1:0]      row_q;
    logic [ACC_W-1:0]   acc [N_ROWS];

    logic               load_hs;
    logic               spike_hs;
    logic               full;
    logic               mem_we;
    logic [PW-1:0]      mem_waddr;
    logic [RW-1:0]      rd_row;
    logic [CW-1:0]      rd_col;
    logic [VAL_W-1:0]   rd_val;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   acc_sum;
    logic               last_entry;

    assign load_ready  = rst_n && (state == IDLE || state == LOAD);
    // A pending load beat always takes priority over a spike vector.
    assign spike_ready = rst_n && state == IDLE && matrix_valid && !load_valid;
    assign load_hs     = load_valid && load_ready;
    assign spike_hs    = spike_valid && spike_ready;

    assign full      = nnz_count == NW'(MAX_NNZ);
    assign mem_we    = load_hs && (state == IDLE || !full);
    assign mem_waddr = (state == IDLE) ? '0 : nnz_count[PW-1:0];

    csr_entry_mem #(
        .DEPTH (MAX_NNZ),
        .AW    (PW),
        .RW    (RW),
        .CW    (CW),
        .VW    (VAL_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wrow  (load_row),
        .wcol  (load_col),
        .wval  (load_val),
        .raddr (ptr[PW-1:0]),
        .rrow  (rd_row),
        .rcol  (rd_col),
        .rval  (rd_val)
    );

    assign addend     = spike_q[rd_col] ? ACC_W'(rd_val) : '0;
    assign acc_sum    = ACC_W'(sat_add(64'(acc[rd_row]), 64'(addend),
                                       ACC_W, SATURATE != 0));
    assign last_entry = (nnz_count == '0) || (ptr == nnz_count - NW'(1));

    assign busy      = state != IDLE;
    assign out_valid = state == DRAIN;
    assign out_row   = row_q;
    assign out_data  = out_valid ? acc[row_q] : '0;
    assign out_last  = out_valid && row_q == RW'(N_ROWS - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            nnz_count    <= '0;
            matrix_valid <= 1'b0;
            err_overflow <= 1'b0;
            err_order    <= 1'b0;
            prev_row     <= '0;
            spike_q      <= '0;
            ptr          <= '0;
            row_q        <= '0;
            for (int i = 0; i < N_ROWS; i++) acc[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_hs) begin
                        nnz_count    <= NW'(1);
                        err_overflow <= 1'b0;
                        err_order    <= 1'b0;
                        prev_row     <= load_row;
                        matrix_valid <= load_last;
                        state        <= load_last ? IDLE : LOAD;
                    end else if (spike_hs) begin
                        spike_q <= spike_in;
                        ptr     <= '0;
                        for (int i = 0; i < N_ROWS; i++) acc[i] <= '0;
                        state   <= COMPUTE;
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        if (full) err_overflow <= 1'b1;
                        else nnz_count <= nnz_count + NW'(1);
                        if (load_row < prev_row) err_order <= 1'b1;
                        prev_row <= load_row;
                        if (load_last) begin
                            matrix_valid <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
                COMPUTE: begin
                    if (nnz_count != '0) acc[rd_row] <= acc_sum;
                    ptr <= ptr + NW'(1);
                    if (last_entry) begin
                        row_q <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (row_q == RW'(N_ROWS - 1)) begin
                            row_q <= '0;
                            state <= IDLE;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
